// File: rtl/alu_arbiter_seq.sv
// ============================================================================
// Module      : alu_arbiter_seq
// Description : Round-robin sharing of one 32-bit ALU between two requesters,
//               with opcode-dependent settle time and a valid/ready response.
//               Optional divide-by-zero short-cut: define ALU_DIV0_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_seq #(
  parameter int SHORT_CYC = 1,
  parameter int LONG_CYC  = 4,
  parameter int MUL_OP    = 10,
  parameter int DIV_OP    = 11
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  localparam int c_max_cyc = (LONG_CYC > SHORT_CYC) ? LONG_CYC : SHORT_CYC;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  localparam logic [c_cnt_w-1:0] c_short = c_cnt_w'(SHORT_CYC);
  localparam logic [c_cnt_w-1:0] c_long  = c_cnt_w'(LONG_CYC);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [4:0]         c_mul   = 5'(MUL_OP);
  localparam logic [4:0]         c_div   = 5'(DIV_OP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_cnt_w-1:0] r_count;
  logic               r_last_grant;
  logic [4:0]         r_alu_op;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [31:0]        r_rsp_hi;
  logic [31:0]        r_rsp_lo;

  logic               w_ready0;
  logic               w_ready1;
  logic               w_accept;
  logic               w_grant;
  logic               w_settle_done;
  logic [4:0]         w_sel_op;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [c_cnt_w-1:0] w_lat;

  assign w_sel_op = w_grant ? req1_op : req0_op;
  assign w_sel_a  = w_grant ? req1_a  : req0_a;
  assign w_sel_b  = w_grant ? req1_b  : req0_b;
  assign w_lat    = ((w_sel_op == c_mul) || (w_sel_op == c_div)) ? c_long : c_short;

  assign w_settle_done = (r_state == ST_SETTLE) && (r_count <= c_one);

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and grant; ready is held low while clear is asserted
  always_comb begin
    w_state_next = r_state;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!clear) begin
          if (req0_valid && (!req1_valid || r_last_grant)) begin
            w_ready0 = 1'b1;
          end else if (req1_valid) begin
            w_ready1 = 1'b1;
          end
        end
        w_accept = w_ready0 | w_ready1;
        w_grant  = w_ready1;
        if (w_accept) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_done) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef ALU_DIV0_CHECK_EN
  logic r_rsp_err;
  logic r_div0;
  logic w_div0;

  assign w_div0  = (w_sel_op == c_div) && (w_sel_b == 32'd0);
  assign rsp_err = r_rsp_err;

  // A zero divisor spends a single cycle in flight and reports zero data
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_rsp_err <= 1'b0;
      r_div0    <= 1'b0;
    end else if (w_accept) begin
      r_rsp_err <= 1'b0;
      r_div0    <= w_div0;
    end else if (w_settle_done && r_div0) begin
      r_rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_alu_op     <= 5'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_hi     <= 32'd0;
      r_rsp_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_op     <= w_sel_op;
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
`ifdef ALU_DIV0_CHECK_EN
            r_count      <= w_div0 ? c_one : w_lat;
`else
            r_count      <= w_lat;
`endif
          end
        end
        ST_SETTLE: begin
          r_count <= r_count - c_one;
          if (w_settle_done) begin
            r_rsp_valid <= 1'b1;
`ifdef ALU_DIV0_CHECK_EN
            if (r_div0) begin
              r_rsp_hi <= 32'd0;
              r_rsp_lo <= 32'd0;
            end else begin
              r_rsp_hi <= alu_result[63:32];
              r_rsp_lo <= alu_result[31:0];
            end
`else
            r_rsp_hi <= alu_result[63:32];
            r_rsp_lo <= alu_result[31:0];
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_hi     = r_rsp_hi;
  assign rsp_lo     = r_rsp_lo;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
// ============================================================================
// Module      : tb_alu_arbiter_seq
// Description : Self-checking bench for alu_arbiter_seq against a
//               transaction-level model; honours ALU_DIV0_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter_seq;

  localparam int         SHORT = 1;
  localparam int         LONG  = 4;
  localparam logic [4:0] MULO  = 5'd10;
  localparam logic [4:0] DIVO  = 5'd11;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_hi, rsp_lo;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_arbiter_seq dut (
    .clock(clock), .clear(clear),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err), .busy(busy)
  );

  // Reference ALU: signed multiply, unsigned divide {rem,quot}, a few others
  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] p;
    case (op)
      5'd0:    alu_f = {32'd0, a + b};
      5'd1:    alu_f = {32'd0, a - b};
      5'd2:    alu_f = {32'd0, a & b};
      5'd10: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        alu_f = p;
      end
      5'd11:   alu_f = (b == 32'd0) ? {64{1'b1}} : {a % b, a / b};
      default: alu_f = {a ^ b, a | b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  // Transaction-level model: one operation in flight, m_left edges to result
  bit          m_inflight, m_last, m_id, m_valid, m_err, m_div0;
  int          m_left;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_r0();
    return !clear && !m_inflight && req0_valid && (!req1_valid || m_last);
  endfunction

  function automatic bit exp_r1();
    return !clear && !m_inflight && req1_valid && (!req0_valid || !m_last);
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_last = 1; m_id = 0; m_valid = 0; m_err = 0; m_div0 = 0;
    m_left = 0; m_op = 5'd0; m_a = 32'd0; m_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic model_step();
    bit g0, g1;
    g0 = exp_r0();
    g1 = exp_r1();
    if (!m_inflight) begin
      if (g0 || g1) begin
        m_id = g1; m_last = g1; m_inflight = 1; m_err = 0; m_div0 = 0;
        m_op = g1 ? req1_op : req0_op;
        m_a  = g1 ? req1_a  : req0_a;
        m_b  = g1 ? req1_b  : req0_b;
        m_left = (m_op == MULO || m_op == DIVO) ? LONG : SHORT;
`ifdef ALU_DIV0_CHECK_EN
        if (m_op == DIVO && m_b == 32'd0) begin
          m_left = 1; m_div0 = 1;
        end
`endif
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1;
        if (m_div0) begin
          m_hi = 32'd0; m_lo = 32'd0; m_err = 1;
        end else begin
          {m_hi, m_lo} = alu_f(m_op, m_a, m_b);
        end
      end
    end else if (rsp_ready) begin
      m_valid = 0; m_inflight = 0;
    end
  endtask

  // Model advances on each active edge; inputs change 1 time unit later
  task automatic step();
    @(posedge clock);
    if (!clear) model_step();
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    model_reset();
    step();
    step();
    clear = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns edges taken after the accept edge
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic logic [4:0] pick_op();
    case ($urandom_range(3))
      0:       return MULO;
      1:       return DIVO;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    return ($urandom_range(4) == 0) ? 32'd0 : 32'($urandom);
  endfunction

  // Compare process: every falling edge, DUT against model
  always @(negedge clock) begin
    check("busy",       64'(busy),       64'(m_inflight));
    check("rsp_valid",  64'(rsp_valid),  64'(m_valid));
    check("rsp_id",     64'(rsp_id),     64'(m_id));
    check("rsp_hi",     64'(rsp_hi),     64'(m_hi));
    check("rsp_lo",     64'(rsp_lo),     64'(m_lo));
    check("rsp_err",    64'(rsp_err),    64'(m_err));
    check("alu_op",     64'(alu_op),     64'(m_op));
    check("alu_a",      64'(alu_a),      64'(m_a));
    check("alu_b",      64'(alu_b),      64'(m_b));
    check("req0_ready", 64'(req0_ready), 64'(exp_r0()));
    check("req1_ready", 64'(req1_ready), 64'(exp_r1()));
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    int n;
    int grants[4];
    logic [31:0] s_hi, s_lo;

    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready  = 0;
    model_reset();
    step();
    step();
    clear = 1'b0;
    check("rst_busy",    64'(busy),      64'd0);
    check("rst_rsp_lo",  64'(rsp_lo),    64'd0);

    // 1: simple add through req0
    req0_valid = 1; req0_op = 5'd0; req0_a = 32'd2; req0_b = 32'd3; rsp_ready = 1;
    #1;
    check("t1_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 0;
    wait_rsp(lat);
    check("t1_latency", 64'(lat),    64'd1);
    check("t1_id",      64'(rsp_id), 64'd0);
    check("t1_lo",      64'(rsp_lo), 64'd5);
    check("t1_hi",      64'(rsp_hi), 64'd0);
    check("t1_model_lo", 64'(m_lo),  64'd5);
    step();
    check("t1_idle", 64'(busy), 64'd0);

    // 2: continuous tie from reset alternates 0,1,0,1
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_op = 5'd0; req1_op = 5'd1;
    req0_a = 32'd100; req0_b = 32'd7; req1_a = 32'd50; req1_b = 32'd8;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("t2_onehot", 64'(req0_ready & req1_ready), 64'd0);
        grants[n] = int'(req1_ready);
        n++;
      end
      step();
    end
    check("t2_count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) check("t2_grant", 64'(grants[k]), 64'(k % 2));
    req0_valid = 0; req1_valid = 0;
    wait_rsp(lat);
    step();

    // 3: signed multiply through req1
    do_reset();
    req1_valid = 1; req1_op = MULO; req1_a = 32'hFFFF_FFFA; req1_b = 32'd5; rsp_ready = 1;
    #1;
    step();
    req1_valid = 0;
    wait_rsp(lat);
    check("t3_latency", 64'(lat), 64'd4);
    check("t3_data",  {rsp_hi, rsp_lo}, 64'hFFFF_FFFF_FFFF_FFE2);
    check("t3_model", {m_hi, m_lo},     64'hFFFF_FFFF_FFFF_FFE2);
    check("t3_id", 64'(rsp_id), 64'd1);
    step();

    // 4: consumer stalls three cycles in the response phase
    req0_valid = 1; req0_op = 5'd2; req0_a = 32'hF0F0_1234; req0_b = 32'hFF00_FFFF;
    rsp_ready = 0;
    #1;
    step();
    req0_valid = 0;
    wait_rsp(lat);
    check("t4_valid", 64'(rsp_valid), 64'd1);
    s_hi = rsp_hi; s_lo = rsp_lo;
    req0_valid = 1; req1_valid = 1; req0_a = 32'd9; req1_a = 32'd11;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_valid", 64'(rsp_valid), 64'd1);
      check("t4_hold_lo",    64'(rsp_lo),    64'(s_lo));
      check("t4_hold_hi",    64'(rsp_hi),    64'(s_hi));
      check("t4_busy",       64'(busy),      64'd1);
      check("t4_readies",    64'({req0_ready, req1_ready}), 64'd0);
    end
    check("t4_lo", 64'(rsp_lo), 64'h0000_1234 & 64'hFFFF_FFFF | 64'hF000_0000);
    rsp_ready = 1;
    step();
    check("t4_released", 64'(busy),      64'd0);
    check("t4_rsp_low",  64'(rsp_valid), 64'd0);

    // 5: clear in the middle of a multiply, then a tie goes to req0
    req1_valid = 0; req0_valid = 1; req0_op = MULO; req0_a = 32'd3; req0_b = 32'd7;
    #1;
    step();
    req0_valid = 0;
    step();
    step();
    check("t5_in_settle", 64'(busy), 64'd1);
    clear = 1'b1;
    model_reset();
    req0_valid = 1; req1_valid = 1;
    #1;
    check("t5_busy",   64'(busy),      64'd0);
    check("t5_alu",    {27'd0, alu_op, alu_a}, 64'd0);
    check("t5_alu_b",  64'(alu_b),     64'd0);
    check("t5_rsp",    {rsp_hi, rsp_lo}, 64'd0);
    check("t5_flags",  64'({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}), 64'd0);
    step();
    clear = 1'b0;
    #1;
    check("t5_tie_r0", 64'(req0_ready), 64'd1);
    check("t5_tie_r1", 64'(req1_ready), 64'd0);
    req0_valid = 0; req1_valid = 0;
    step();

    // 6: divide by zero
    rsp_ready = 1;
    req0_valid = 1; req0_op = DIVO; req0_a = 32'd8; req0_b = 32'd0;
    #1;
    step();
    req0_valid = 0;
    wait_rsp(lat);
`ifdef ALU_DIV0_CHECK_EN
    check("t6_latency", 64'(lat),     64'd1);
    check("t6_err",     64'(rsp_err), 64'd1);
    check("t6_data",    {rsp_hi, rsp_lo}, 64'd0);
`else
    check("t6_latency", 64'(lat),     64'd4);
    check("t6_err",     64'(rsp_err), 64'd0);
    check("t6_data",    {rsp_hi, rsp_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    step();

    // Random traffic, including inputs changing while not accepted
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom_range(2) != 0);
      req1_valid = ($urandom_range(2) != 0);
      req0_op = pick_op(); req0_a = 32'($urandom); req0_b = pick_b();
      req1_op = pick_op(); req1_a = 32'($urandom); req1_b = pick_b();
      rsp_ready = ($urandom_range(3) != 0);
      if ($urandom_range(499) == 0) begin
        clear = 1'b1;
        model_reset();
        step();
        clear = 1'b0;
      end else begin
        step();
      end
    end

    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int k = 0; k < 8; k++) step();
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
